// File: rtl/arm_mc_cpu.sv
// arm_mc_cpu: multicycle ARMv4-subset core. Instructions and data share one
// req/ready memory port, so the controller tolerates wait states of any length.
// Optional macro ARM_MC_PERF_EN adds the cycle_cnt / instret performance counters.
module arm_mc_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_adr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ready,
  input  logic [31:0]      mem_rdata,
  output logic [3:0]       flags
`ifdef ARM_MC_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
`endif
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_ALUWB,
    S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d;
  logic [31:0] a_q, a_d, b_q, b_d, wd_q, wd_d;
  logic [31:0] alu_out_q, alu_out_d, data_q, data_d;
  logic        alu_c_q, alu_c_d, alu_v_q, alu_v_d;
  logic [3:0]  flags_q, flags_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_adr_q, mem_adr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] rf_q [16];

  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        to_fetch;
  logic [31:0] fetch_pc, op2, res, eff;
  logic [32:0] sum;

  // Instruction fields, operand reads (R15 reads as instr_addr+8) and decode
  logic [3:0]  opcode;
  logic        is_sub, is_arith, is_cmp, op_ok, is_dp, is_mem, is_b, cond_ok;
  logic [31:0] rn_val, rm_val, rd_val, imm32, rot_imm, br_off;
  logic [4:0]  rot_sh;

  assign opcode   = ir_q[24:21];
  assign is_sub   = (opcode == 4'b0010) || (opcode == 4'b1010);
  assign is_arith = is_sub || (opcode == 4'b0100);
  assign is_cmp   = (opcode == 4'b1010);
  assign op_ok    = is_arith || (opcode == 4'b0000) || (opcode == 4'b1100);
  assign is_dp    = (ir_q[27:26] == 2'b00) && op_ok && (ir_q[25] || (ir_q[11:4] == 8'h00));
  assign is_mem   = (ir_q[27:26] == 2'b01) && !ir_q[25] && ir_q[24] && !ir_q[22] && !ir_q[21];
  assign is_b     = (ir_q[27:25] == 3'b101) && !ir_q[24];
  assign rn_val   = (ir_q[19:16] == 4'hF) ? pc_q + 32'd4 : rf_q[ir_q[19:16]];
  assign rm_val   = (ir_q[3:0]   == 4'hF) ? pc_q + 32'd4 : rf_q[ir_q[3:0]];
  assign rd_val   = (ir_q[15:12] == 4'hF) ? pc_q + 32'd4 : rf_q[ir_q[15:12]];
  assign imm32    = {24'h0, ir_q[7:0]};
  assign rot_sh   = {ir_q[11:8], 1'b0};
  assign rot_imm  = (imm32 >> rot_sh) | (imm32 << (6'd32 - {1'b0, rot_sh}));
  assign br_off   = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};

  // Condition field evaluation against the current NZCV flags
  always_comb begin
    cond_ok = 1'b0;
    case (ir_q[31:28])
      4'h0: cond_ok = flags_q[2];
      4'h1: cond_ok = !flags_q[2];
      4'h2: cond_ok = flags_q[1];
      4'h3: cond_ok = !flags_q[1];
      4'h4: cond_ok = flags_q[3];
      4'h5: cond_ok = !flags_q[3];
      4'h6: cond_ok = flags_q[0];
      4'h7: cond_ok = !flags_q[0];
      4'h8: cond_ok = flags_q[1] && !flags_q[2];
      4'h9: cond_ok = !flags_q[1] || flags_q[2];
      4'hA: cond_ok = (flags_q[3] == flags_q[0]);
      4'hB: cond_ok = (flags_q[3] != flags_q[0]);
      4'hC: cond_ok = !flags_q[2] && (flags_q[3] == flags_q[0]);
      4'hD: cond_ok = flags_q[2] || (flags_q[3] != flags_q[0]);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Controller next-state, datapath updates and next values of the registered memory port
  always_comb begin
    state_d = state_q;  pc_d = pc_q;  ir_d = ir_q;
    a_d = a_q;  b_d = b_q;  wd_d = wd_q;
    alu_out_d = alu_out_q;  alu_c_d = alu_c_q;  alu_v_d = alu_v_q;
    data_d = data_q;  flags_d = flags_q;
    mem_req_d = mem_req_q;  mem_we_d = mem_we_q;
    mem_adr_d = mem_adr_q;  mem_wdata_d = mem_wdata_q;
    rf_we = 1'b0;  rf_wa = ir_q[15:12];  rf_wd = alu_out_q;
    to_fetch = 1'b0;  fetch_pc = pc_q;
    op2 = b_q;  res = '0;  sum = '0;  eff = '0;
    case (state_q)
      S_FETCH: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
          mem_we_d  = 1'b0;
          mem_adr_d = pc_q & 32'hFFFF_FFFC;
        end else if (mem_ready) begin
          ir_d      = mem_rdata;
          pc_d      = pc_q + 32'd4;
          mem_req_d = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rn_val;
        b_d = rm_val;
        wd_d = rd_val;
        if (!cond_ok)    to_fetch = 1'b1;
        else if (is_dp)  state_d = ir_q[25] ? S_EXECI : S_EXECR;
        else if (is_mem) state_d = S_MEMADR;
        else if (is_b)   state_d = S_BRANCH;
        else             to_fetch = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        op2 = (state_q == S_EXECI) ? rot_imm : b_q;
        sum = is_sub ? ({1'b0, a_q} + {1'b0, ~op2} + 33'd1) : ({1'b0, a_q} + {1'b0, op2});
        case (opcode)
          4'b0000: res = a_q & op2;
          4'b1100: res = a_q | op2;
          default: res = sum[31:0];
        endcase
        alu_out_d = res;
        alu_c_d   = sum[32];
        alu_v_d   = is_sub ? ((a_q[31] != op2[31]) && (sum[31] != a_q[31]))
                           : ((a_q[31] == op2[31]) && (sum[31] != a_q[31]));
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        if (ir_q[20] || is_cmp)
          flags_d = {alu_out_q[31], (alu_out_q == 32'h0),
                     is_arith ? alu_c_q : flags_q[1], is_arith ? alu_v_q : flags_q[0]};
        if (!is_cmp) begin
          if (ir_q[15:12] == 4'hF) fetch_pc = alu_out_q;
          else rf_we = 1'b1;
        end
        to_fetch = 1'b1;
      end
      S_MEMADR: begin
        eff       = ir_q[23] ? a_q + {20'h0, ir_q[11:0]} : a_q - {20'h0, ir_q[11:0]};
        mem_req_d = 1'b1;
        mem_adr_d = eff & 32'hFFFF_FFFC;
        if (ir_q[20]) begin
          mem_we_d = 1'b0;
          state_d  = S_MEMRD;
        end else begin
          mem_we_d    = 1'b1;
          mem_wdata_d = wd_q;
          state_d     = S_MEMWR;
        end
      end
      S_MEMRD: begin
        if (mem_ready) begin
          data_d    = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_wd = data_q;
        if (ir_q[15:12] == 4'hF) fetch_pc = data_q;
        else rf_we = 1'b1;
        to_fetch = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) to_fetch = 1'b1;
      end
      S_BRANCH: begin
        fetch_pc = pc_q + 32'd4 + br_off;
        to_fetch = 1'b1;
      end
      default: to_fetch = 1'b1;
    endcase
    if (to_fetch) begin
      state_d   = S_FETCH;
      pc_d      = fetch_pc;
      mem_req_d = 1'b1;
      mem_we_d  = 1'b0;
      mem_adr_d = fetch_pc & 32'hFFFF_FFFC;
    end
  end

  // State, datapath and register-file update; reset abandons any pending access
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;  pc_q <= RESET_PC;  ir_q <= '0;
      a_q <= '0;  b_q <= '0;  wd_q <= '0;
      alu_out_q <= '0;  alu_c_q <= 1'b0;  alu_v_q <= 1'b0;
      data_q <= '0;  flags_q <= '0;
      mem_req_q <= 1'b0;  mem_we_q <= 1'b0;  mem_adr_q <= '0;  mem_wdata_q <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;  pc_q <= pc_d;  ir_q <= ir_d;
      a_q <= a_d;  b_q <= b_d;  wd_q <= wd_d;
      alu_out_q <= alu_out_d;  alu_c_q <= alu_c_d;  alu_v_q <= alu_v_d;
      data_q <= data_d;  flags_q <= flags_d;
      mem_req_q <= mem_req_d;  mem_we_q <= mem_we_d;
      mem_adr_q <= mem_adr_d;  mem_wdata_q <= mem_wdata_d;
      if (rf_we && (rf_wa != 4'hF)) rf_q[rf_wa] <= rf_wd;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_wdata = mem_wdata_q;
  assign flags     = flags_q;

`ifdef ARM_MC_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_q, instret_q;

  // Performance counters: every non-reset cycle, and every return to FETCH
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      instret_q   <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if ((state_d == S_FETCH) && (state_q != S_FETCH)) instret_q <= instret_q + 1'b1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instret   = instret_q;
`else
  logic perf_unused;
  assign perf_unused = (CNT_W > 0);
`endif

endmodule
